// File: rtl/fingerprint_tx_scheduler_if.sv
// FIFO write-side port between the fingerprint scheduler and the SPI FIFO.
// Carries the write strobe and data plus the FIFO's write-domain fill level and full flag.
interface fingerprint_tx_scheduler_if #(
  parameter int unsigned FREQ_W     = 9,
  parameter int unsigned FIFO_ASIZE = 6
);
  logic                  wr_en;
  logic [FREQ_W-1:0]     wr_data;
  logic [FIFO_ASIZE:0]   fifo_wcount;
  logic                  fifo_wfull;

  modport master (
    output wr_en,
    output wr_data,
    input  fifo_wcount,
    input  fifo_wfull
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output fifo_wcount,
    output fifo_wfull
  );
endinterface

// File: rtl/fingerprint_tx_scheduler.sv
// Admits whole frames of spectral maxima into the SPI FIFO when they fit and streams their frequencies.
// Optional frame marker word: define FRAME_HEADER_EN.
module fingerprint_tx_scheduler #(
  parameter int unsigned NUM_BINS   = 16,
  parameter int unsigned BIN_W      = 25,
  parameter int unsigned FREQ_W     = 9,
  parameter int unsigned FIFO_ASIZE = 6
`ifdef FRAME_HEADER_EN
  ,
  parameter logic [FREQ_W-1:0] HEADER_WORD = 9'h1FF
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_valid_i,
  input  logic [NUM_BINS*BIN_W-1:0] frame_data_i,
  fingerprint_tx_scheduler_if.master fifo,
  output logic                      busy_o,
  output logic [15:0]               frame_count_o,
  output logic [15:0]               drop_count_o
);

`ifdef FRAME_HEADER_EN
  localparam int unsigned FrameLen = NUM_BINS + 1;
`else
  localparam int unsigned FrameLen = NUM_BINS;
`endif
  localparam int unsigned IdxW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BINS - 1);
  localparam logic [FIFO_ASIZE:0] FifoDepth = (FIFO_ASIZE + 1)'(2 ** FIFO_ASIZE);
  localparam logic [FIFO_ASIZE:0] FrameLenW = (FIFO_ASIZE + 1)'(FrameLen);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCheck  = 2'd1,
`ifdef FRAME_HEADER_EN
    StHeader = 2'd2,
`endif
    StSend   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [FREQ_W-1:0] shadow_q [NUM_BINS];
  logic [FREQ_W-1:0] shadow_d [NUM_BINS];
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [15:0]       drop_count_q, drop_count_d;

  logic                wr_en;
  logic [FREQ_W-1:0]   wr_data;
  logic [FIFO_ASIZE:0] space;
  logic                fits;
  logic                last_write;
  logic                drop_event;

  // Only the frequency field of each bin is forwarded; magnitudes are discarded.
  logic unused_frame_bits;
  assign unused_frame_bits = ^frame_data_i;

  assign space      = FifoDepth - fifo.fifo_wcount;
  assign fits       = (space >= FrameLenW);
  assign last_write = (state_q == StSend) && wr_en && (idx_q == LastIdx);
  // A CHECK failure and an overrun in the same cycle share a single increment.
  assign drop_event = (frame_valid_i && (state_q != StIdle)) ||
                      ((state_q == StCheck) && !fits);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (frame_valid_i) state_d = StCheck;
      end
      StCheck: begin
`ifdef FRAME_HEADER_EN
        state_d = fits ? StHeader : StIdle;
`else
        state_d = fits ? StSend : StIdle;
`endif
      end
`ifdef FRAME_HEADER_EN
      StHeader: begin
        if (wr_en) state_d = StSend;
      end
`endif
      StSend: begin
        if (last_write) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state_q)
`ifdef FRAME_HEADER_EN
      StHeader: begin
        wr_en   = !fifo.fifo_wfull;
        wr_data = HEADER_WORD;
      end
`endif
      StSend: begin
        wr_en   = !fifo.fifo_wfull;
        wr_data = shadow_q[idx_q];
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = '0;
      end
    endcase
  end

  assign fifo.wr_en    = wr_en;
  assign fifo.wr_data  = wr_data;
  assign busy_o        = (state_q != StIdle);
  assign frame_count_o = frame_count_q;
  assign drop_count_o  = drop_count_q;

  always_comb begin
    shadow_d      = shadow_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    if ((state_q == StIdle) && frame_valid_i) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        shadow_d[i] = frame_data_i[i*BIN_W +: FREQ_W];
      end
      idx_d = '0;
    end
    if ((state_q == StSend) && wr_en) begin
      idx_d = idx_q + 1'b1;
    end
    if (last_write) begin
      frame_count_d = frame_count_q + 16'd1;
    end
    if (drop_event && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      idx_q         <= idx_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Payload storage needs no reset: it is always loaded before it is read.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

endmodule
